mult_seq_ctrl: RTL

Sequencing controller for the processor's multiply resource.
- Accepts MULT (signed) and MULTU (unsigned) requests and runs an iterative shift-add multiply, one bit per clock.
- Owns the architectural HI/LO registers and services MTHI/MTLO writes.
- Supplies BUSY so the pipeline stalls MFHI/MFLO and new multiplies until the result is committed.

---
 rtl/mult_seq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add multiply controller owning the architectural HI/LO pair.
// One multiplier bit per clock, followed by a sign fix-up cycle and a commit cycle.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [WIDTH:0]     add_sum;

  // Two's-complement magnitude; the most negative value maps onto its unsigned twin.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    if (is_signed && v[WIDTH-1])
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Upper half plus the multiplicand, keeping the carry so the shift loses nothing.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0])
      add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      HI    <= '0;
      LO    <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MTHI)
            HI <= WDATA;
          if (MTLO)
            LO <= WDATA;
          if (START) begin
            // The multiplier rides in the low half and is consumed as the product shifts in.
            mcand <= magnitude(A, SIGNED);
            acc   <= {{WIDTH{1'b0}}, magnitude(B, SIGNED)};
            neg   <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          acc <= {add_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= ST_FIX;
        end

        ST_FIX: begin
          if (neg)
            acc <= negate_wide(acc);
          state <= ST_DONE;
        end

        ST_DONE: begin
          // DONE doubles as the phase bit: first edge commits, second edge releases.
          if (!DONE) begin
            HI   <= acc[2*WIDTH-1:WIDTH];
            LO   <= acc[WIDTH-1:0];
            DONE <= 1'b1;
          end else begin
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
